// File: rtl/seq_ctrl_pkg.sv
// Shared definitions for seq_controller: token-chain geometry helpers and FSM state encodings.
package seq_ctrl_pkg;

  localparam logic SeqIdleEnc = 1'b0;
  localparam logic SeqRunEnc  = 1'b1;

  typedef enum logic {
    StIdle = SeqIdleEnc,
    StRun  = SeqRunEnc
  } seq_state_e;

  // Token chain: capture[1..] positions, then the op window, then the valid slot.
  function automatic int unsigned token_len(int unsigned num_capture, int unsigned op_cycles);
    return num_capture + op_cycles;
  endfunction

  function automatic int unsigned op_start_idx(int unsigned num_capture);
    return num_capture - 1;
  endfunction

  function automatic int unsigned op_end_idx(int unsigned num_capture, int unsigned op_cycles);
    return num_capture + op_cycles - 2;
  endfunction

  function automatic int unsigned cnt_width(int unsigned op_cycles);
    return $clog2(op_cycles + 1);
  endfunction

endpackage

// File: rtl/seq_token_sr.sv
// Serial-in shift register with synchronous active-low clear; carries one token per operation.
module seq_token_sr #(
  parameter int unsigned Len = 2
) (
  input  logic           clk_i,
  input  logic           clr_ni,
  input  logic           din_i,
  output logic [Len-1:0] q_o
);

  logic [Len-1:0] q_q, q_d;

  always_comb begin
    q_d = {q_q[Len-2:0], din_i};
  end

  always_ff @(posedge clk_i) begin
    if (!clr_ni) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/seq_controller.sv
// Capture/operate/valid sequencer with ready/busy handshake and optional pipelined issue.
// Define SEQ_CONTROLLER_OVERRUN_EN to add the sticky overrun flag and its clear input.
module seq_controller
  import seq_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CAPTURE = 3,
  parameter int unsigned OP_CYCLES   = 1,
  parameter int unsigned PIPELINED   = 0
) (
  input  logic                   clock,
  input  logic                   rst_n,
  input  logic                   start,
`ifdef SEQ_CONTROLLER_OVERRUN_EN
  input  logic                   overrun_clr,
  output logic                   overrun,
`endif
  output logic                   ready,
  output logic                   busy,
  output logic [NUM_CAPTURE-1:0] capture,
  output logic                   op,
  output logic                   valid
);

  localparam int unsigned Len     = token_len(NUM_CAPTURE, OP_CYCLES);
  localparam int unsigned OpStart = op_start_idx(NUM_CAPTURE);
  localparam int unsigned OpEnd   = op_end_idx(NUM_CAPTURE, OP_CYCLES);
  localparam int unsigned CntW    = cnt_width(OP_CYCLES);

  if (NUM_CAPTURE < 1) begin : g_bad_num_capture
    $error("seq_controller: NUM_CAPTURE must be >= 1");
  end
  if (OP_CYCLES < 1) begin : g_bad_op_cycles
    $error("seq_controller: OP_CYCLES must be >= 1");
  end
  if (PIPELINED > 1) begin : g_bad_pipelined
    $error("seq_controller: PIPELINED must be 0 or 1");
  end

  logic [Len-1:0] tok;
  logic           ready_int;
  logic           acc;

  // ready_int already folds in rst_n, so no accept can happen during reset.
  assign acc = start & ready_int;

  seq_token_sr #(
    .Len(Len)
  ) u_token_sr (
    .clk_i (clock),
    .clr_ni(rst_n),
    .din_i (acc),
    .q_o   (tok)
  );

  if (PIPELINED == 0) begin : g_fsm
    seq_state_e state_q, state_d;

    always_comb begin
      state_d = state_q;
      unique case (state_q)
        StIdle:  if (acc) state_d = StRun;
        StRun:   if (tok[Len-1]) state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end

    always_ff @(posedge clock) begin
      if (!rst_n) begin
        state_q <= StIdle;
      end else begin
        state_q <= state_d;
      end
    end

    assign ready_int = rst_n & (state_q == StIdle);
  end else begin : g_pipe
    logic [CntW-1:0] cnt_q, cnt_d;

    // Spacing accepts by OP_CYCLES keeps successive op windows disjoint.
    always_comb begin
      cnt_d = cnt_q;
      if (acc) begin
        cnt_d = CntW'(OP_CYCLES - 1);
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - CntW'(1);
      end
    end

    always_ff @(posedge clock) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign ready_int = rst_n & (cnt_q == '0);
  end

  assign ready      = ready_int;
  assign busy       = rst_n & (|tok);
  assign op         = rst_n & (|tok[OpEnd:OpStart]);
  assign valid      = rst_n & tok[Len-1];
  assign capture[0] = acc;

  if (NUM_CAPTURE > 1) begin : g_capture_hi
    assign capture[NUM_CAPTURE-1:1] = {(NUM_CAPTURE - 1){rst_n}} & tok[NUM_CAPTURE-2:0];
  end

`ifdef SEQ_CONTROLLER_OVERRUN_EN
  logic overrun_q, overrun_d;

  // Set takes priority over a same-cycle clear.
  always_comb begin
    overrun_d = (start & ~ready_int) | (overrun_q & ~overrun_clr);
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign overrun = rst_n & overrun_q;
`else
  // Starts dropped while not ready are ignored without any indication.
`endif

endmodule
